// File: rtl/ir_code_capture.sv
// ir_code_capture: IR receive/learn front end.
// Samples a raw carrier-modulated IR signal. It measures the carrier half-period in
// clocks, then the mark and space durations in units of UNIT_DIV clocks. The results
// are queued as tagged records in a small FIFO, which is read out with valid/ready.
//
// Ports:
//   clock_in       system clock
//   reset_n_in     asynchronous active-low reset
//   enable_in      capture armed when high; low aborts the current frame
//   ir_in          raw IR input (asynchronous, active-high carrier)
//   rec_valid_out  record available at FIFO head
//   rec_ready_in   pops the head when rec_valid_out is also high
//   rec_tag_out    00 CARRIER, 01 MARK, 10 SPACE, 11 END
//   rec_value_out  record payload
//   busy_out       frame in progress
//   overflow_out   sticky record-dropped flag, cleared on enable_in rising
//
// state    | meaning
// ST_IDLE  | waiting for a rising edge with capture enabled
// ST_MARK  | inside a carrier burst, edges keep arriving
// ST_SPACE | carrier timed out, measuring the gap to the next burst
module ir_code_capture #(
    parameter int CTC_WIDTH       = 8,
    parameter int DELAY_WIDTH     = 16,
    parameter int UNIT_DIV        = 16,
    parameter int CARRIER_TIMEOUT = 512,
    parameter int GAP_UNITS       = 4096,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   enable_in,
    input  logic                   ir_in,
    output logic                   rec_valid_out,
    input  logic                   rec_ready_in,
    output logic [1:0]             rec_tag_out,
    output logic [DELAY_WIDTH-1:0] rec_value_out,
    output logic                   busy_out,
    output logic                   overflow_out
);
    localparam int DW = DELAY_WIDTH;
    localparam int PW = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
    localparam int GW = $clog2(CARRIER_TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] TAG_CARRIER = 2'b00;
    localparam logic [1:0] TAG_MARK    = 2'b01;
    localparam logic [1:0] TAG_SPACE   = 2'b10;
    localparam logic [1:0] TAG_END     = 2'b11;

    localparam logic [31:0]   CTC_MAX   = (32'd1 << CTC_WIDTH) - 32'd1;
    localparam logic [GW-1:0] GAP_TO    = GW'(CARRIER_TIMEOUT);
    localparam logic [DW-1:0] GAP_U     = DW'(GAP_UNITS);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    // A phase starts on the edge cycle itself, so the first stored value
    // already represents one elapsed clock.
    localparam logic [PW-1:0] PRE_RST   = (UNIT_DIV == 1) ? '0 : PW'(1);
    localparam logic [DW-1:0] UNITS_RST = (UNIT_DIV == 1) ? DW'(1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE} state_t;

    state_t          state;
    logic            ir_s1, ir_s2, ir_d, en_d, ir_rise;
    logic [PW-1:0]   m_pre, s_pre;
    logic [DW-1:0]   m_units, s_units, mark_len, mark_cnt;
    logic [GW-1:0]   gap, gap_half;
    logic            car_done;
    logic [DW-1:0]   car_val;

    logic            push, do_push, pop, full;
    logic [1:0]      push_tag;
    logic [DW-1:0]   push_val;
    logic [1:0]      mem_tag [FIFO_DEPTH];
    logic [DW-1:0]   mem_val [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    function automatic logic [PW-1:0] pre_next(input logic [PW-1:0] p);
        return (p == PW'(UNIT_DIV - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [DW-1:0] units_next(input logic [PW-1:0] p, input logic [DW-1:0] u);
        return (p == PW'(UNIT_DIV - 1) && u != '1) ? u + 1'b1 : u;
    endfunction

    assign ir_rise  = ir_s2 & ~ir_d;
    assign gap_half = gap >> 1;
    assign car_val  = (32'(gap_half) > CTC_MAX) ? DW'(CTC_MAX) : DW'(gap_half);

    always_comb begin
        push     = 1'b0;
        push_tag = TAG_CARRIER;
        push_val = '0;
        if (enable_in) begin
            case (state)
                ST_MARK: begin
                    if (ir_rise) begin
                        if (!car_done && mark_cnt == '0) begin
                            push     = 1'b1;
                            push_tag = TAG_CARRIER;
                            push_val = car_val;
                        end
                    end else if (gap == GAP_TO) begin
                        push     = 1'b1;
                        push_tag = TAG_MARK;
                        push_val = mark_len;
                    end
                end
                ST_SPACE: begin
                    if (ir_rise) begin
                        push     = 1'b1;
                        push_tag = TAG_SPACE;
                        push_val = s_units;
                    end else if (s_units == GAP_U) begin
                        push     = 1'b1;
                        push_tag = TAG_END;
                        push_val = mark_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
            ir_s1    <= 1'b0;
            ir_s2    <= 1'b0;
            ir_d     <= 1'b0;
            en_d     <= 1'b0;
            m_pre    <= '0;
            m_units  <= '0;
            s_pre    <= '0;
            s_units  <= '0;
            gap      <= '0;
            mark_len <= '0;
            mark_cnt <= '0;
            car_done <= 1'b0;
        end else begin
            ir_s1 <= ir_in;
            ir_s2 <= ir_s1;
            ir_d  <= ir_s2;
            en_d  <= enable_in;
            if (!enable_in) begin
                state    <= ST_IDLE;
                busy_out <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ir_rise) begin
                            state    <= ST_MARK;
                            busy_out <= 1'b1;
                            m_pre    <= PRE_RST;
                            m_units  <= UNITS_RST;
                            s_pre    <= PRE_RST;
                            s_units  <= UNITS_RST;
                            gap      <= GW'(1);
                            mark_len <= '0;
                            mark_cnt <= '0;
                            car_done <= 1'b0;
                        end
                    end
                    ST_MARK: begin
                        m_pre   <= pre_next(m_pre);
                        m_units <= units_next(m_pre, m_units);
                        if (ir_rise) begin
                            // Space is measured from the last edge of the mark.
                            gap      <= GW'(1);
                            mark_len <= m_units;
                            s_pre    <= PRE_RST;
                            s_units  <= UNITS_RST;
                            if (mark_cnt == '0)
                                car_done <= 1'b1;
                        end else begin
                            s_pre   <= pre_next(s_pre);
                            s_units <= units_next(s_pre, s_units);
                            if (gap == GAP_TO) begin
                                state <= ST_SPACE;
                                if (mark_cnt != '1)
                                    mark_cnt <= mark_cnt + 1'b1;
                            end else begin
                                gap <= gap + 1'b1;
                            end
                        end
                    end
                    ST_SPACE: begin
                        if (ir_rise) begin
                            state    <= ST_MARK;
                            m_pre    <= PRE_RST;
                            m_units  <= UNITS_RST;
                            s_pre    <= PRE_RST;
                            s_units  <= UNITS_RST;
                            gap      <= GW'(1);
                            mark_len <= '0;
                        end else if (s_units == GAP_U) begin
                            state    <= ST_IDLE;
                            busy_out <= 1'b0;
                        end else begin
                            s_pre   <= pre_next(s_pre);
                            s_units <= units_next(s_pre, s_units);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Record FIFO; a simultaneous pop frees the slot a full-FIFO push needs.
    assign full    = (count == FULL_CNT);
    assign pop     = (count != '0) && rec_ready_in;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clock_in) begin
        if (do_push) begin
            mem_tag[wr_ptr] <= push_tag;
            mem_val[wr_ptr] <= push_val;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (enable_in && !en_d)
                overflow_out <= 1'b0;
            else if (push && full && !pop)
                overflow_out <= 1'b1;
        end
    end

    // Head payload is forced to zero while empty so reset shows all-zero outputs.
    assign rec_valid_out = (count != '0);
    assign rec_tag_out   = rec_valid_out ? mem_tag[rd_ptr] : 2'b00;
    assign rec_value_out = rec_valid_out ? mem_val[rd_ptr] : '0;

endmodule

// File: tb/tb_ir_code_capture.sv
module tb_ir_code_capture;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          ir = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [1:0]    tag;
    logic [DW-1:0] value;
    logic          busy;
    logic          ovf;

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rise = 0;
    int p3 = 0;
    int rec_q[$];
    int exp_q[$];

    ir_code_capture #(
        .CTC_WIDTH(8), .DELAY_WIDTH(DW), .UNIT_DIV(4),
        .CARRIER_TIMEOUT(64), .GAP_UNITS(50), .FIFO_DEPTH(4)
    ) dut (
        .clock_in(clk), .reset_n_in(rst_n), .enable_in(enable), .ir_in(ir),
        .rec_valid_out(valid), .rec_ready_in(ready), .rec_tag_out(tag),
        .rec_value_out(value), .busy_out(busy), .overflow_out(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 ns after posedge, so the negedge view is what the next posedge sees.
    always @(negedge clk)
        if (rst_n && valid && ready)
            rec_q.push_back(int'(tag) * 65536 + int'(value));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int rec(input int t, input int v);
        return t * 65536 + v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            ir = 1'b1;
            last_rise = cyc;
            repeat (10) tick();
            ir = 1'b0;
            repeat (10) tick();
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 1000) begin
            tick();
            k++;
        end
        chk({name, " idle"}, busy, 0);
    endtask

    task automatic check_recs(input string name);
        chk({name, " count"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rec_q.size())
                chk($sformatf("%s rec%0d", name, i), rec_q[i], exp_q[i]);
        rec_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #12;
        chk("reset valid", valid, 0);
        chk("reset tag", tag, 0);
        chk("reset value", value, 0);
        chk("reset busy", busy, 0);
        chk("reset ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        ready = 1'b1;
        repeat (3) tick();

        // single burst; END is pushed 200 clocks after the last recognised edge
        pulses(20);
        while (cyc < last_rise + 202) tick();
        chk("t1 busy before end", busy, 1);
        tick();
        chk("t1 busy after end", busy, 0);
        repeat (3) tick();
        exp_q = '{rec(0, 10), rec(1, 95), rec(3, 1)};
        check_recs("t1");

        // two bursts, 150-clock space -> floor(150/4) = 37
        pulses(20);
        while (cyc < last_rise + 150) tick();
        pulses(20);
        wait_idle("t2");
        repeat (3) tick();
        exp_q = '{rec(0, 10), rec(1, 95), rec(2, 37), rec(1, 95), rec(3, 2)};
        check_recs("t2");

        // backpressure: 3 bursts of 3 pulses, ready low, FIFO holds 4
        ready = 1'b0;
        pulses(3);
        while (cyc < last_rise + 100) tick();
        pulses(3);
        while (cyc < last_rise + 100) tick();
        chk("t3 ovf before", ovf, 0);
        chk("t3 stall valid", valid, 1);
        chk("t3 stall tag", tag, 0);
        chk("t3 stall value", value, 10);
        ir = 1'b1;
        p3 = cyc;
        last_rise = cyc;
        tick();
        tick();
        chk("t3 ovf at 4 pushes", ovf, 0);
        tick();
        chk("t3 ovf at 5th push", ovf, 1);
        repeat (7) tick();
        ir = 1'b0;
        repeat (10) tick();
        pulses(2);
        wait_idle("t3");
        chk("t3 stall tag late", tag, 0);
        chk("t3 stall value late", value, 10);
        ready = 1'b1;
        repeat (6) tick();
        chk("t3 drained", valid, 0);
        chk("t3 ovf sticky", ovf, 1);
        exp_q = '{rec(0, 10), rec(1, 10), rec(2, 25), rec(1, 10)};
        check_recs("t3");

        // saturation: 2000-clock carrier, then a single-edge mark
        pulses(100);
        wait_idle("t4a");
        repeat (3) tick();
        exp_q = '{rec(0, 10), rec(1, 255), rec(3, 1)};
        check_recs("t4a");
        pulses(1);
        wait_idle("t4b");
        repeat (3) tick();
        exp_q = '{rec(1, 0), rec(3, 1)};
        check_recs("t4b");

        // abort mid-mark
        ready = 1'b0;
        pulses(3);
        chk("t5 busy in mark", busy, 1);
        enable = 1'b0;
        tick();
        chk("t5 busy after abort", busy, 0);
        chk("t5 ovf retained", ovf, 1);
        chk("t5 fifo valid", valid, 1);
        chk("t5 fifo tag", tag, 0);
        chk("t5 fifo value", value, 10);
        pulses(2);
        repeat (250) tick();
        chk("t5 stays idle", busy, 0);
        ready = 1'b1;
        repeat (4) tick();
        exp_q = '{rec(0, 10)};
        check_recs("t5");
        ready = 1'b0;
        enable = 1'b1;
        tick();
        chk("t5 ovf cleared", ovf, 0);

        // async reset mid-frame
        pulses(3);
        chk("t6 busy pre", busy, 1);
        chk("t6 valid pre", valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst valid", valid, 0);
        chk("t6 rst tag", tag, 0);
        chk("t6 rst value", value, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst ovf", ovf, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (3) tick();
        chk("t6 fifo empty", valid, 0);
        pulses(20);
        wait_idle("t6");
        repeat (3) tick();
        exp_q = '{rec(0, 10), rec(1, 95), rec(3, 1)};
        check_recs("t6");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
